classificador_botao: RTL and testbench



---
 rtl/classificador_botao_pkg.sv | 16 +
 rtl/classificador_botao_sincronizador.sv | 25 ++
 rtl/classificador_botao.sv | 107 ++++++++++
 tb/tb_classificador_botao.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/classificador_botao_pkg.sv
// Shared types and default timing for the lamp-control slice:
// button-classifier FSM states and the default debounce/long-press lengths.
package pkg_luz;

    typedef enum logic [2:0] {
        IDLE,
        DEB_PRESS,
        PRESSED,
        DEB_RELEASE,
        WAIT_RELEASE
    } estado_t;

    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int LONG_CYCLES_DEF     = 20;

endpackage

// File: rtl/classificador_botao_sincronizador.sv
// Two-flop synchronizer for asynchronous inputs; both stages clear on reset.
module sincronizador
    import pkg_luz::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            dout <= '0;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/classificador_botao.sv
// Classifies a raw push-button into long-press (a) and short-press (b) pulses
// and synchronizes the presence sensor into the level d.
module classificador_botao
    import pkg_luz::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int LONG_CYCLES     = LONG_CYCLES_DEF,
    parameter int CNT_W           = $clog2(LONG_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic botao,
    input  logic presenca,
    output logic a,
    output logic b,
    output logic d
);

    localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(LONG_CYCLES - 1);

    logic             botao_s;
    estado_t          state, state_n;
    logic [CNT_W-1:0] deb_cnt, deb_n;
    logic [CNT_W-1:0] hold_cnt, hold_n;
    logic             a_n, b_n;

    sincronizador #(.WIDTH(1)) u_sync_botao (
        .clk  (clk),
        .rst  (rst),
        .din  (botao),
        .dout (botao_s)
    );

    sincronizador #(.WIDTH(1)) u_sync_presenca (
        .clk  (clk),
        .rst  (rst),
        .din  (presenca),
        .dout (d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            deb_cnt  <= '0;
            hold_cnt <= '0;
            a        <= 1'b0;
            b        <= 1'b0;
        end else begin
            state    <= state_n;
            deb_cnt  <= deb_n;
            hold_cnt <= hold_n;
            a        <= a_n;
            b        <= b_n;
        end
    end

    always_comb begin
        state_n = state;
        deb_n   = deb_cnt;
        hold_n  = hold_cnt;
        a_n     = 1'b0;
        b_n     = 1'b0;

        case (state)
            IDLE: begin
                if (botao_s) state_n = DEB_PRESS;
            end
            DEB_PRESS: begin
                if (!botao_s)                state_n = IDLE;
                else if (deb_cnt == DEB_MAX) state_n = PRESSED;
                else                         deb_n   = deb_cnt + 1'b1;
            end
            PRESSED: begin
                if (botao_s && hold_cnt == HOLD_MAX) begin
                    a_n     = 1'b1;
                    state_n = WAIT_RELEASE;
                end else if (!botao_s) begin
                    state_n = DEB_RELEASE;
                end
                if (hold_cnt != HOLD_MAX) hold_n = hold_cnt + 1'b1;
            end
            DEB_RELEASE: begin
                // A release that bounces back just resumes the same hold.
                if (botao_s) begin
                    state_n = PRESSED;
                end else if (deb_cnt == DEB_MAX) begin
                    b_n     = 1'b1;
                    state_n = IDLE;
                end else begin
                    deb_n = deb_cnt + 1'b1;
                end
                if (hold_cnt != HOLD_MAX) hold_n = hold_cnt + 1'b1;
            end
            WAIT_RELEASE: begin
                if (botao_s)                 deb_n   = '0;
                else if (deb_cnt == DEB_MAX) state_n = IDLE;
                else                         deb_n   = deb_cnt + 1'b1;
            end
            default: state_n = IDLE;
        endcase

        if (state_n != state) deb_n = '0;
        if (state == DEB_PRESS && state_n == PRESSED) hold_n = '0;
    end

endmodule

// File: tb/tb_classificador_botao.sv
// Scenario bench for classificador_botao: pulses are predicted into a queue
// at stimulus time and matched cycle-exactly as the DUT emits them.
module tb_classificador_botao;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic botao = 1'b0;
    logic presenca = 1'b0;
    logic a, b, d;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    typedef struct {
        bit is_a;
        int cyc;
    } exp_t;

    exp_t q[$];
    logic [1:0] want;

    classificador_botao dut (
        .clk      (clk),
        .rst      (rst),
        .botao    (botao),
        .presenca (presenca),
        .a        (a),
        .b        (b),
        .d        (d)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: a raw edge driven in cycle C is first sampled by edge C+1;
    // b follows 6 edges later, a long press 26 edges later (both seen at C+7 / C+27).
    always @(negedge clk) begin
        if (mon_en) begin
            if (q.size() > 0 && q[0].cyc == cyc) begin
                want = q[0].is_a ? 2'b10 : 2'b01;
                checks++;
                if ({a, b} !== want) begin
                    errors++;
                    $display("FAIL pulse@%0d: a,b=%b%b required %b", cyc, a, b, want);
                end
                void'(q.pop_front());
            end else if (a !== 1'b0 || b !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL spurious@%0d: a,b=%b%b required 00", cyc, a, b);
            end
        end
    end

    task automatic settle(output int left);
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (12) @(negedge clk);
        left = q.size();
    endtask

    task automatic test_reset();
        rst = 1'b1; botao = 1'b1; presenca = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({a, b, d} !== 3'b000) begin
                errors++;
                $display("FAIL reset_out: a,b,d=%b%b%b required 000", a, b, d);
            end
        end
        botao = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (d !== 1'b0) begin
            errors++;
            $display("FAIL d_lat1: d=%b required 0", d);
        end
        @(negedge clk);
        checks++;
        if (d !== 1'b1) begin
            errors++;
            $display("FAIL d_lat2: d=%b required 1", d);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_presenca();
        presenca = 1'b0;
        @(negedge clk);
        checks++;
        if (d !== 1'b1) begin
            errors++;
            $display("FAIL d_fall1: d=%b required 1", d);
        end
        @(negedge clk);
        checks++;
        if (d !== 1'b0) begin
            errors++;
            $display("FAIL d_fall2: d=%b required 0", d);
        end
    endtask

    task automatic test_short_press();
        int left;
        botao = 1'b1;
        repeat (10) @(negedge clk);
        botao = 1'b0;
        q.push_back('{1'b0, cyc + 7});
        settle(left);
        checks++;
        if (left !== 0) begin
            errors++;
            $display("FAIL short_press: pending=%0d required 0", left);
        end
    endtask

    task automatic test_bounce_reject();
        int left;
        botao = 1'b1;
        repeat (2) @(negedge clk);
        botao = 1'b0;
        @(negedge clk);
        botao = 1'b1;
        @(negedge clk);
        botao = 1'b0;
        settle(left);
        checks++;
        if (left !== 0) begin
            errors++;
            $display("FAIL bounce_reject: pending=%0d required 0", left);
        end
    endtask

    task automatic test_long_press();
        int left;
        botao = 1'b1;
        q.push_back('{1'b1, cyc + 27});
        repeat (40) @(negedge clk);
        botao = 1'b0;
        settle(left);
        checks++;
        if (left !== 0) begin
            errors++;
            $display("FAIL long_press: pending=%0d required 0", left);
        end
    endtask

    task automatic test_release_bounce();
        int left;
        botao = 1'b1;
        repeat (10) @(negedge clk);
        botao = 1'b0;
        repeat (2) @(negedge clk);
        botao = 1'b1;
        repeat (3) @(negedge clk);
        botao = 1'b0;
        q.push_back('{1'b0, cyc + 7});
        settle(left);
        checks++;
        if (left !== 0) begin
            errors++;
            $display("FAIL release_bounce: pending=%0d required 0", left);
        end
    endtask

    task automatic test_reset_mid_hold();
        int left;
        presenca = 1'b1;
        botao = 1'b1;
        repeat (15) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (d !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_d: d=%b required 0", d);
        end
        @(negedge clk);
        rst = 1'b0;
        q.push_back('{1'b1, cyc + 27});
        repeat (40) @(negedge clk);
        botao = 1'b0;
        settle(left);
        checks++;
        if (left !== 0) begin
            errors++;
            $display("FAIL reset_mid_hold: pending=%0d required 0", left);
        end
    endtask

    initial begin
        test_reset();
        test_presenca();
        test_short_press();
        test_bounce_reject();
        test_long_press();
        test_release_bounce();
        test_short_press();
        test_reset_mid_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time=%0t required finish before 500000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
